// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with back-to-back framing
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   load_valid  parallel word offered on pdata
//   pdata       parallel word, sampled only on acceptance
//   load_ready  a word can be accepted this cycle (state/cnt only)
//   sout        serial data bit, registered
//   sout_valid  sout carries a frame bit, registered
//   sout_last   sout carries the final bit of the frame, registered
//   busy        frame in progress
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] pdata,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sout_last_q, sout_last_d;

    logic at_last;
    logic accept;
    logic first_bit;
    logic next_bit;

    // cnt indexes the bit currently presented on sout.
    assign at_last    = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign load_ready = (state_q == IDLE) || at_last;
    assign accept     = load_valid && load_ready;

    // shreg keeps the word aligned so that the bit on sout sits at the
    // transmit end; the following bit is therefore one position inward.
    assign first_bit = (MSB_FIRST != 0) ? pdata[WIDTH-1]   : pdata[0];
    assign next_bit  = (MSB_FIRST != 0) ? shreg_q[WIDTH-2] : shreg_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        sout_last_d  = sout_last_q;

        if (accept) begin
            // Covers both IDLE start and the zero-gap reload on the last bit.
            state_d      = SHIFT;
            cnt_d        = '0;
            shreg_d      = pdata;
            sout_d       = first_bit;
            sout_valid_d = 1'b1;
            sout_last_d  = 1'b0;
        end else if (state_q == SHIFT && !at_last) begin
            cnt_d        = cnt_q + CW'(1);
            shreg_d      = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
            sout_d       = next_bit;
            sout_valid_d = 1'b1;
            sout_last_d  = ((cnt_q + CW'(1)) == LAST_IDX);
        end else begin
            state_d      = IDLE;
            cnt_d        = '0;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            sout_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - self-checking bench for piso_tx, MSB-first and LSB-first instances
module tb_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] pdata;

    logic m_ready, m_sout, m_valid, m_last, m_busy;
    logic l_ready, l_sout, l_valid, l_last, l_busy;

    int checks   = 0;
    int failures = 0;

    // Reference: queue of bits still owed on the wire, head = bit on sout now.
    bit           q_m[$];
    bit           q_l[$];
    logic [W-1:0] words[$];
    logic [W-1:0] sr_m = '0;
    logic [W-1:0] sr_l = '0;
    bit           obs[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .load_valid(load_valid), .pdata(pdata),
        .load_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
        .sout_last(m_last), .busy(m_busy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .load_valid(load_valid), .pdata(pdata),
        .load_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
        .sout_last(l_last), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic lv, input logic [W-1:0] pd);
        bit acc;
        bit exp_ready;
        @(negedge clk);
        rst        = r;
        load_valid = lv;
        pdata      = pd;
        exp_ready  = (q_m.size() <= 1);
        acc        = !r && lv && exp_ready;
        #1;
        chk("m_ready_pre", 32'(m_ready), 32'(exp_ready));
        chk("l_ready_pre", 32'(l_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        if (r) begin
            q_m.delete();
            q_l.delete();
            words.delete();
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(pd[i]);
                for (int i = 0; i < W; i++) q_l.push_back(pd[i]);
                words.push_back(pd);
            end
        end
        chk("m_sout",  32'(m_sout),  32'((q_m.size() > 0) ? q_m[0] : 1'b0));
        chk("m_valid", 32'(m_valid), 32'(q_m.size() > 0));
        chk("m_last",  32'(m_last),  32'(q_m.size() == 1));
        chk("m_busy",  32'(m_busy),  32'(q_m.size() > 0));
        chk("m_ready", 32'(m_ready), 32'(q_m.size() <= 1));
        chk("l_sout",  32'(l_sout),  32'((q_l.size() > 0) ? q_l[0] : 1'b0));
        chk("l_valid", 32'(l_valid), 32'(q_l.size() > 0));
        chk("l_last",  32'(l_last),  32'(q_l.size() == 1));
        chk("l_busy",  32'(l_busy),  32'(q_l.size() > 0));
        // Independent loopback: a serial-in register rebuilds the word.
        if (m_valid) begin
            sr_m = {sr_m[W-2:0], m_sout};
            obs.push_back(m_sout);
        end
        if (l_valid) sr_l = {l_sout, sr_l[W-1:1]};
        if (q_m.size() == 1 && words.size() > 0) begin
            chk("loop_m", 32'(sr_m), 32'(words[0]));
            chk("loop_l", 32'(sr_l), 32'(words[0]));
            void'(words.pop_front());
        end
    endtask

    initial begin
        logic [7:0]   seq;
        logic [W-1:0] cur;
        int           n;
        int           guard;
        bit           lv;
        bit           pre_ready;

        rst = 1'b1; load_valid = 1'b0; pdata = '0;
        cycle(1'b1, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);
        chk("reset_ready", 32'(m_ready), 32'd1);
        chk("reset_valid", 32'(m_valid), 32'd0);

        // Single frame 1011, MSB first -> 1,0,1,1
        obs.delete();
        cycle(1'b0, 1'b1, 4'b1011);
        repeat (5) cycle(1'b0, 1'b0, 4'h0);
        seq = '0;
        for (int i = 0; i < obs.size() && i < 8; i++) seq[7-i] = obs[i];
        chk("seq1011_len", 32'(obs.size()), 32'd4);
        chk("seq1011",     32'(seq[7:4]),   32'h0000000b);

        // LSB-first patterns
        cycle(1'b0, 1'b1, 4'b0001);
        repeat (5) cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 4'b1000);
        repeat (5) cycle(1'b0, 1'b0, 4'h0);

        // Back-to-back: 1011 then 0110 held until accepted on the last bit
        obs.delete();
        cycle(1'b0, 1'b1, 4'b1011);
        repeat (4) cycle(1'b0, 1'b1, 4'b0110);
        repeat (5) cycle(1'b0, 1'b0, 4'h0);
        seq = '0;
        for (int i = 0; i < obs.size() && i < 8; i++) seq[7-i] = obs[i];
        chk("b2b_len", 32'(obs.size()), 32'd8);
        chk("b2b_seq", 32'(seq),        32'h000000b6);

        // Offer 1111 during frame 0000: ignored until the last bit
        cycle(1'b0, 1'b1, 4'b0000);
        repeat (4) cycle(1'b0, 1'b1, 4'b1111);
        repeat (5) cycle(1'b0, 1'b0, 4'h0);

        // Reset mid-frame after two bits of 1100
        cycle(1'b0, 1'b1, 4'b1100);
        cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);
        chk("abort_busy",  32'(m_busy),  32'd0);
        chk("abort_ready", 32'(m_ready), 32'd1);
        repeat (3) cycle(1'b0, 1'b0, 4'h0);

        // Reset wins over acceptance in the same cycle
        cycle(1'b1, 1'b1, 4'b1010);
        chk("rst_drop_valid", 32'(m_valid), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 4'h0);

        // Random traffic: 50 accepted words, source holds word until taken
        n     = 0;
        guard = 0;
        cur   = W'($urandom);
        while (n < 50 && guard < 2000) begin
            lv        = ($urandom_range(0, 3) != 0);
            pre_ready = (q_m.size() <= 1);
            cycle(1'b0, lv, cur);
            if (lv && pre_ready) begin
                n++;
                cur = W'($urandom);
            end
            guard++;
        end
        chk("random_words", 32'(n), 32'd50);
        repeat (6) cycle(1'b0, 1'b0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
